// File: rtl/triangle_area_mc.sv
// Multi-cycle shoelace triangle area: one shared multiplier, held valid/ready result.
// Define TRIANGLE_ORIENT_EN to produce the ccw/degenerate flags; otherwise they stay 0.
module triangle_area_mc #(
  parameter int W    = 11,
  parameter bit HALF = 1'b0
) (
  input  logic           CLOCK_50,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   ax,
  input  logic [W-1:0]   ay,
  input  logic [W-1:0]   bx,
  input  logic [W-1:0]   by,
  input  logic [W-1:0]   cx,
  input  logic [W-1:0]   cy,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] area,
  output logic           ccw,
  output logic           degenerate
);
  typedef enum logic [2:0] {IDLE, M0, M1, M2, FIN, DONE} state_t;

  typedef struct packed {
    logic [W-1:0] ax, ay, bx, by, cx, cy;
  } vtx_t;

  state_t                 state_q, state_d;
  vtx_t                   vtx_q, vtx_d;
  logic signed [2*W+2:0]  acc_q, acc_d;
  logic [2*W-1:0]         area_q, area_d;
  logic                   ccw_q, ccw_d;
  logic                   degen_q, degen_d;
  logic                   out_valid_q, out_valid_d;

  logic [W-1:0]           mul_a, sub_p, sub_n;
  logic signed [W:0]      diff;
  logic signed [2*W+1:0]  op_a, op_b, prod;
  logic signed [2*W+2:0]  prod_ext;
  logic [2*W+2:0]         mag;

  // The single multiplier: operands steered by which shoelace term is due.
  always_comb begin
    mul_a = '0;
    sub_p = '0;
    sub_n = '0;
    case (state_q)
      M0:      begin mul_a = vtx_q.ax; sub_p = vtx_q.by; sub_n = vtx_q.cy; end
      M1:      begin mul_a = vtx_q.bx; sub_p = vtx_q.cy; sub_n = vtx_q.ay; end
      M2:      begin mul_a = vtx_q.cx; sub_p = vtx_q.ay; sub_n = vtx_q.by; end
      default: ;
    endcase
    diff     = $signed({1'b0, sub_p}) - $signed({1'b0, sub_n});
    op_a     = {{(W+2){1'b0}}, mul_a};
    op_b     = {{(W+1){diff[W]}}, diff};
    prod     = op_a * op_b;
    prod_ext = {prod[2*W+1], prod};
    mag      = acc_q[2*W+2] ? -acc_q : acc_q;
  end

  always_comb begin
    state_d     = state_q;
    vtx_d       = vtx_q;
    acc_d       = acc_q;
    area_d      = area_q;
    ccw_d       = ccw_q;
    degen_d     = degen_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: if (in_valid) begin
        vtx_d   = '{ax: ax, ay: ay, bx: bx, by: by, cx: cx, cy: cy};
        state_d = M0;
      end
      M0: begin acc_d = prod_ext;         state_d = M1;  end
      M1: begin acc_d = acc_q + prod_ext; state_d = M2;  end
      M2: begin acc_d = acc_q + prod_ext; state_d = FIN; end
      FIN: begin
        // |2A| never exceeds 2W bits, so the casts only drop zero bits.
        area_d = HALF ? (2*W)'(mag >> 1) : (2*W)'(mag);
`ifdef TRIANGLE_ORIENT_EN
        ccw_d   = !acc_q[2*W+2] && (acc_q != '0);
        degen_d = (acc_q == '0);
`endif
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: if (out_ready) begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      vtx_q       <= '0;
      acc_q       <= '0;
      area_q      <= '0;
      ccw_q       <= 1'b0;
      degen_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      vtx_q       <= vtx_d;
      acc_q       <= acc_d;
      area_q      <= area_d;
      ccw_q       <= ccw_d;
      degen_q     <= degen_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = out_valid_q;
  assign area       = area_q;
  assign ccw        = ccw_q;
  assign degenerate = degen_q;
endmodule

// File: tb/tb_triangle_area_mc.sv
// Bench for triangle_area_mc: HALF=0 and HALF=1 instances driven in lockstep,
// checked against a plain-arithmetic shoelace model.
module tb_triangle_area_mc;
  localparam int W = 11;

  logic           clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [W-1:0]   ax = '0, ay = '0, bx = '0, by = '0, cx = '0, cy = '0;
  logic           in_ready0, in_ready1, out_valid0, out_valid1;
  logic [2*W-1:0] area0, area1;
  logic           ccw0, ccw1, deg0, deg1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  triangle_area_mc #(.W(W), .HALF(1'b0)) dut0 (
    .CLOCK_50(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
    .out_valid(out_valid0), .out_ready(out_ready), .area(area0),
    .ccw(ccw0), .degenerate(deg0));

  triangle_area_mc #(.W(W), .HALF(1'b1)) dut1 (
    .CLOCK_50(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .ax(ax), .ay(ay), .bx(bx), .by(by), .cx(cx), .cy(cy),
    .out_valid(out_valid1), .out_ready(out_ready), .area(area1),
    .ccw(ccw1), .degenerate(deg1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint twice_area(input int pax, pay, pbx, pby, pcx, pcy);
    return longint'(pax) * (pby - pcy) + longint'(pbx) * (pcy - pay) + longint'(pcx) * (pay - pby);
  endfunction

  function automatic logic [W-1:0] rnd();
    return W'($urandom_range(0, (1 << W) - 1));
  endfunction

  task automatic scramble();
    ax = rnd(); ay = rnd(); bx = rnd(); by = rnd(); cx = rnd(); cy = rnd();
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready0 && n < 20) begin @(posedge clk); #1; n++; end
    if (!in_ready0) chk("in_ready_timeout", 64'(in_ready0), 64'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready0), 64'd1);
    chk({tag, "_out_valid"}, 64'(out_valid0 | out_valid1), 64'd0);
    chk({tag, "_area0"}, 64'(area0), 64'd0);
    chk({tag, "_area1"}, 64'(area1), 64'd0);
    chk({tag, "_flags"}, 64'({ccw0, deg0, ccw1, deg1}), 64'd0);
  endtask

  // One transaction; handshakes at E5 when out_ready is already high.
  task automatic txn(input string tag, input int pax, pay, pbx, pby, pcx, pcy);
    longint s = twice_area(pax, pay, pbx, pby, pcx, pcy);
    longint m = (s < 0) ? -s : s;
    logic e_ccw = 1'b0, e_deg = 1'b0;
`ifdef TRIANGLE_ORIENT_EN
    e_ccw = (s > 0);
    e_deg = (s == 0);
`endif
    wait_ready();
    ax = W'(pax); ay = W'(pay); bx = W'(pbx); by = W'(pby); cx = W'(pcx); cy = W'(pcy);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
    chk({tag, "_busy"}, 64'(in_ready0), 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk({tag, "_early"}, 64'(out_valid0), 64'd0);
    end
    @(posedge clk); #1;
    chk({tag, "_valid"}, 64'({out_valid0, out_valid1}), 64'd3);
    chk({tag, "_area"}, 64'(area0), 64'(m));
    chk({tag, "_area_half"}, 64'(area1), 64'(m >> 1));
    chk({tag, "_ccw"}, 64'({ccw0, ccw1}), 64'({e_ccw, e_ccw}));
    chk({tag, "_degen"}, 64'({deg0, deg1}), 64'({e_deg, e_deg}));
    if (out_ready) begin
      @(posedge clk); #1;
      chk({tag, "_hs"}, 64'({out_valid0, in_ready0}), 64'b01);
      chk({tag, "_hold"}, 64'(area0), 64'(m));
    end
  endtask

  initial begin
    logic [2*W-1:0] held0, held1;
    #1;
    check_reset_vals("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    txn("plan1", 1, 82, 47, 1, 47, 165);
    txn("plan2", 1, 5, 15, 25, 3, 50);
    txn("plan2_swap", 1, 5, 3, 50, 15, 25);
    txn("collinear", 0, 0, 5, 5, 10, 10);
    txn("extreme", 0, 0, 2047, 0, 0, 2047);
    txn("extreme_cw", 0, 0, 0, 2047, 2047, 0);
    txn("all_max", 2047, 2047, 2047, 2047, 2047, 2047);
    for (int i = 0; i < 8; i++)
      txn("random", int'(rnd()), int'(rnd()), int'(rnd()), int'(rnd()), int'(rnd()), int'(rnd()));

    // Back-pressure: result must hold while the upstream side thrashes.
    out_ready = 1'b0;
    txn("bp", 3, 1000, 2000, 7, 1500, 1800);
    held0 = area0; held1 = area1;
    for (int i = 0; i < 20; i++) begin
      in_valid = ~in_valid;
      scramble();
      @(posedge clk); #1;
      chk("bp_valid", 64'({out_valid0, out_valid1}), 64'd3);
      chk("bp_area", 64'({area0, area1}), 64'({held0, held1}));
      chk("bp_in_ready", 64'({in_ready0, in_ready1}), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", 64'({out_valid0, in_ready0}), 64'b01);
    chk("bp_keep", 64'(area0), 64'(held0));

    // Reset during M1 aborts the transaction with no stray result.
    wait_ready();
    ax = 11'd10; ay = 11'd20; bx = 11'd300; by = 11'd40; cx = 11'd50; cy = 11'd600;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_reset_vals("abort");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("abort_no_valid", 64'(out_valid0 | out_valid1), 64'd0);
    end
    txn("after_reset", 10, 20, 300, 40, 50, 600);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
